// File: rtl/regfile_mp.sv
// Multi-port register file: NR combinational read ports, two write ports (port 1 wins), x0 hardwired to zero.
// Writes land one edge later (optionally bypassed to reads same cycle); after reset an NREGS-cycle clear runs and ready gates writes.
module regfile_mp #(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter int NR     = 2,
  parameter int BYPASS = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we0,
  input  logic [AW-1:0]      wa0,
  input  logic [XLEN-1:0]    wd0,
  input  logic               we1,
  input  logic [AW-1:0]      wa1,
  input  logic [XLEN-1:0]    wd1,
  input  logic [NR*AW-1:0]   ra,
  output logic [NR*XLEN-1:0] rd,
  output logic               ready,
  output logic               wr_conflict
);

  localparam int NREGS = 2**AW;

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     clr_ptr_q, clr_ptr_d;
  logic              wr_conflict_q, wr_conflict_d;
  logic [XLEN-1:0]   regs_q [NREGS];
  logic [XLEN-1:0]   regs_d [NREGS];
  logic [AW-1:0]     rai;
  logic [XLEN-1:0]   val;

  always_comb begin
    state_d       = state_q;
    clr_ptr_d     = clr_ptr_q;
    wr_conflict_d = 1'b0;
    regs_d        = regs_q;
    if (state_q == CLEAR) begin
      regs_d[clr_ptr_q] = '0;
      clr_ptr_d         = clr_ptr_q + 1'b1;
      if (clr_ptr_q == AW'(NREGS - 1)) begin
        state_d = RUN;
      end
    end else begin
      // port 1 is applied last so it overrides port 0 on an address clash
      if (we0 && (wa0 != '0)) regs_d[wa0] = wd0;
      if (we1 && (wa1 != '0)) regs_d[wa1] = wd1;
      wr_conflict_d = we0 && we1 && (wa0 == wa1) && (wa0 != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= CLEAR;
      clr_ptr_q     <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_ptr_q     <= clr_ptr_d;
      wr_conflict_q <= wr_conflict_d;
      regs_q        <= regs_d;
    end
  end

  always_comb begin
    rd  = '0;
    rai = '0;
    val = '0;
    for (int i = 0; i < NR; i++) begin
      rai = ra[i*AW +: AW];
      val = regs_q[rai];
      if ((BYPASS != 0) && we0 && (wa0 == rai)) val = wd0;
      if ((BYPASS != 0) && we1 && (wa1 == rai)) val = wd1;
      if ((rai == '0) || (state_q != RUN)) val = '0;
      rd[i*XLEN +: XLEN] = val;
    end
  end

  assign ready       = (state_q == RUN);
  assign wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: constant vector table, hand sequences for clear/bypass, random run against a reference model.
module tb_regfile_mp;

  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int NREGS = 32;

  logic              clk = 1'b0;
  logic              rst, we0, we1;
  logic [AW-1:0]     wa0, wa1;
  logic [XLEN-1:0]   wd0, wd1;
  logic [NR*AW-1:0]  ra;
  logic [NR*XLEN-1:0] rd_b, rd_nb;
  logic              ready_b, ready_nb, conf_b, conf_nb;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [XLEN-1:0] mem [NREGS];
  bit   ready_m;
  bit   conf_m;
  int   clr_left;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(XLEN), .AW(AW), .NR(NR), .BYPASS(1)) dut_b (
    .clk(clk), .rst(rst), .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra(ra), .rd(rd_b), .ready(ready_b), .wr_conflict(conf_b));

  regfile_mp #(.XLEN(XLEN), .AW(AW), .NR(NR), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra(ra), .rd(rd_nb), .ready(ready_nb), .wr_conflict(conf_nb));

  typedef struct {
    logic            we0;
    logic [AW-1:0]   wa0;
    logic [XLEN-1:0] wd0;
    logic            we1;
    logic [AW-1:0]   wa1;
    logic [XLEN-1:0] wd1;
    logic [AW-1:0]   ra0;
    logic [AW-1:0]   ra1;
    logic [XLEN-1:0] e0;
    logic [XLEN-1:0] e1;
    logic            econf;
  } vec_t;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
    if (!ready_m || a == '0) return '0;
    if (byp && we1 && wa1 == a) return wd1;
    if (byp && we0 && wa0 == a) return wd0;
    return mem[a];
  endfunction

  function automatic void model_update();
    if (rst) begin
      clr_left = NREGS;
      ready_m  = 1'b0;
      conf_m   = 1'b0;
    end else if (!ready_m) begin
      conf_m = 1'b0;
      clr_left--;
      if (clr_left == 0) begin
        ready_m = 1'b1;
        for (int k = 0; k < NREGS; k++) mem[k] = '0;
      end
    end else begin
      conf_m = we0 && we1 && (wa0 == wa1) && (wa0 != '0);
      if (we0 && wa0 != '0) mem[wa0] = wd0;
      if (we1 && wa1 != '0) mem[wa1] = wd1;
    end
  endfunction

  task automatic check_all();
    check("ready_byp",    {31'd0, ready_b},  {31'd0, ready_m});
    check("ready_nobyp",  {31'd0, ready_nb}, {31'd0, ready_m});
    check("conflict_byp", {31'd0, conf_b},   {31'd0, conf_m});
    check("conflict_nob", {31'd0, conf_nb},  {31'd0, conf_m});
    for (int p = 0; p < NR; p++) begin
      check($sformatf("rd_byp[%0d] ra=%0d", p, ra[p*AW +: AW]), rd_b[p*XLEN +: XLEN], exp_rd(ra[p*AW +: AW], 1'b1));
      check($sformatf("rd_nob[%0d] ra=%0d", p, ra[p*AW +: AW]), rd_nb[p*XLEN +: XLEN], exp_rd(ra[p*AW +: AW], 1'b0));
    end
  endtask

  task automatic check_and_advance();
    check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic step();
    @(negedge clk);
    check_and_advance();
  endtask

  // Counts negedges with ready low; returns sitting at the first negedge with ready high.
  task automatic count_clear(output int cnt);
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (ready_b) break;
      cnt++;
      check_and_advance();
    end
  endtask

  task automatic idle_inputs();
    we0 = 1'b0; wa0 = '0; wd0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0;
  endtask

  vec_t tbl [11];
  int   cnt;

  initial begin
    tbl[0]  = '{1'b1, 5'd17, 32'h3,        1'b0, 5'd0,  32'h0,        5'd17, 5'd18, 32'h3,        32'h0,        1'b0};
    tbl[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd17, 5'd18, 32'h3,        32'h0,        1'b0};
    tbl[2]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0,  32'h1234,     5'd0,  5'd0,  32'h0,        32'h0,        1'b0};
    tbl[3]  = '{1'b1, 5'd9,  32'h11,       1'b1, 5'd9,  32'h22,       5'd9,  5'd17, 32'h22,       32'h3,        1'b0};
    tbl[4]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd9,  5'd0,  32'h22,       32'h0,        1'b1};
    tbl[5]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd4,  32'hA5A5A5A5, 5'd4,  5'd9,  32'hA5A5A5A5, 32'h22,       1'b0};
    tbl[6]  = '{1'b1, 5'd18, 32'h77,       1'b1, 5'd19, 32'h88,       5'd18, 5'd19, 32'h77,       32'h88,       1'b0};
    tbl[7]  = '{1'b1, 5'd5,  32'h1,        1'b1, 5'd5,  32'h2,        5'd5,  5'd4,  32'h2,        32'hA5A5A5A5, 1'b0};
    tbl[8]  = '{1'b1, 5'd5,  32'h3,        1'b1, 5'd5,  32'h4,        5'd5,  5'd5,  32'h4,        32'h4,        1'b1};
    tbl[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd5,  5'd19, 32'h4,        32'h88,       1'b1};
    tbl[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd18, 5'd0,  32'h77,       32'h0,        1'b0};

    rst = 1'b1;
    idle_inputs();
    ra = '0;
    @(posedge clk);
    model_update();
    #1;
    step();
    rst = 1'b0;
    count_clear(cnt);
    check("initial_clear_cycles", cnt, 32);
    check_and_advance();

    for (int i = 0; i < 11; i++) begin
      we0 = tbl[i].we0; wa0 = tbl[i].wa0; wd0 = tbl[i].wd0;
      we1 = tbl[i].we1; wa1 = tbl[i].wa1; wd1 = tbl[i].wd1;
      ra  = {tbl[i].ra1, tbl[i].ra0};
      @(negedge clk);
      check($sformatf("tbl%0d_rd0", i), rd_b[0 +: XLEN], tbl[i].e0);
      check($sformatf("tbl%0d_rd1", i), rd_b[XLEN +: XLEN], tbl[i].e1);
      check($sformatf("tbl%0d_conflict", i), {31'd0, conf_b}, {31'd0, tbl[i].econf});
      check_and_advance();
    end

    // same-cycle forwarding only on the bypass instance
    idle_inputs();
    we1 = 1'b1; wa1 = 5'd20; wd1 = 32'h5A5A5A5A;
    ra  = {5'd0, 5'd20};
    @(negedge clk);
    check("bypass_same_cycle", rd_b[0 +: XLEN], 32'h5A5A5A5A);
    check("nobypass_old_value", rd_nb[0 +: XLEN], 32'h0);
    check_and_advance();
    idle_inputs();
    @(negedge clk);
    check("nobypass_after_edge", rd_nb[0 +: XLEN], 32'h5A5A5A5A);
    check_and_advance();

    // preload x5, reset, then x5 must read back cleared
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF;
    step();
    idle_inputs();
    ra = {5'd0, 5'd5};
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    count_clear(cnt);
    check("reclear_cycles", cnt, 32);
    check("x5_after_clear", rd_b[0 +: XLEN], 32'h0);
    check_and_advance();

    // writes held during clear, with a second reset mid-clear
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h33333333;
    ra  = {5'd3, 5'd3};
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    count_clear(cnt);
    check("midclear_reset_cycles", cnt, 32);
    check("x3_after_clear", rd_nb[0 +: XLEN], 32'h0);
    check_and_advance();
    idle_inputs();
    step();

    for (int k = 0; k < 2000; k++) begin
      rst = ($urandom_range(0, 199) == 0);
      we0 = $urandom_range(0, 1);
      we1 = $urandom_range(0, 1);
      wa0 = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, 31));
      wa1 = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, 31));
      wd0 = $urandom;
      wd1 = $urandom;
      ra  = {AW'($urandom_range(0, 31)), AW'($urandom_range(0, 3))};
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file, successor to the single-write/dual-read register file in the RISC-V datapath. It adds a configurable data width, register count and read-port count, a second write port for dual-issue writeback, optional write-to-read bypass, and a hardware clear sequence after reset. It sits between decode (read addresses) and writeback (write ports), in the same position as the existing register file.

## Interface

- XLEN, 32, data width in bits
- AW, 5, address width; register count NREGS = 2**AW
- NR, 2, number of read ports (1..4)
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see stored value only

- clk  in  1  rising-edge clock, single clock domain
- rst  in  1  reset, synchronous, active-high
- we0  in  1  write enable, port 0
- wa0  in  AW  write address, port 0
- wd0  in  XLEN  write data, port 0
- we1  in  1  write enable, port 1 (priority port)
- wa1  in  AW  write address, port 1
- wd1  in  XLEN  write data, port 1
- ra  in  NR*AW  read addresses; port i = ra[i*AW +: AW]
- rd  out  NR*XLEN  read data; port i = rd[i*XLEN +: XLEN], combinational
- ready  out  1  high when clear sequence is done and writes are accepted
- wr_conflict  out  1  registered one-cycle pulse: both ports wrote the same nonzero address

## Operation

- Register 0 is hardwired to zero. Writes to address 0 are discarded. Reads of address 0 return 0 on every port, in every state.
- FSM states: CLEAR and RUN.
  - rst high: state <= CLEAR, clr_ptr <= 0, ready <= 0, wr_conflict <= 0.
  - CLEAR, rst low: on each edge, reg[clr_ptr] <= 0 and clr_ptr <= clr_ptr+1. Clearing reg 0 is harmless.
  - When clr_ptr == NREGS-1 is cleared: state <= RUN, ready <= 1.
  - RUN: stays in RUN until rst.
- Writes are accepted only in RUN, when ready=1.
  - In CLEAR, we0/we1 are ignored entirely: no array write, no bypass, no conflict flag.
- Write rules, in RUN:
  - weN && waN != 0: reg[waN] <= wdN at the edge.
  - Both ports enabled with the same nonzero address: port 1 wins, and wr_conflict = 1 in the following cycle.
- Read rules:
  - In CLEAR, every rd port returns 0, whatever the array contents.
  - In RUN, rd_i = reg[ra_i].
  - Bypass (BYPASS=1, RUN): if we1 && wa1 == ra_i != 0, rd_i = wd1. Otherwise, if we0 && wa0 == ra_i != 0, rd_i = wd0. Otherwise, the stored value.
- All NR read ports are independent. Any number of ports may read the same address.
- No X propagation: the array is fully defined after the clear sequence. No initial blocks are used for functional values.

## Timing

- Reset values: ready = 0, wr_conflict = 0, and rd = 0 on all ports, for as long as the FSM is in CLEAR.
- Clear latency: let rst be sampled high at edge E0 and low from edge E1 onward. Then edges E1..E_NREGS clear the registers, and ready = 1 after edge E_NREGS. With the defaults this is 32 cycles.
- rst asserted mid-operation or mid-clear restarts the sequence from clr_ptr = 0. A pending write in that same cycle is dropped.
- Write latency: written data is visible from the array one edge after the write. With BYPASS=1 it is also visible combinationally in the same cycle.
- Read path is purely combinational, from ra/we/wa/wd to rd. There is no read latency.
- wr_conflict is asserted for exactly one cycle per conflicting edge. It stays high on back-to-back conflicts.

## Test plan

- Reset/clear: preload by writing 0xDEADBEEF to x5, then pulse rst for 1 cycle -> ready low for exactly 32 cycles, rd=0 on all ports during CLEAR, x5 reads 0 once ready=1.
- Basic write/read: in RUN, we0=1, wa0=17, wd0=3 -> next cycle, ra port0=17 returns 0x00000003; a simultaneous read of x18 on port1 returns its own stored value.
- x0 hardwire: we0=1, wa0=0, wd0=0xFFFFFFFF -> rd returns 0 on every port for ra=0; wr_conflict stays 0 even if we1 also targets 0.
- Port priority/conflict: we0 and we1 both enabled, wa0 = wa1 = 9, wd0 = 0x11, wd1 = 0x22 -> x9 reads 0x22 next cycle; wr_conflict = 1 for exactly that one cycle.
- Bypass: BYPASS=1, we1 = 1, wa1 = 4, wd1 = 0xA5A5A5A5, ra port0 = 4 in the same cycle -> rd0 = 0xA5A5A5A5 in the same cycle. With BYPASS=0 the same stimulus gives the old value until after the edge.
- Writes during CLEAR and reset mid-clear: assert rst at clear cycle 10, with we0 = 1, wa0 = 3 active throughout -> ready still takes a full 32 cycles after rst falls; x3 reads 0.
